// File: rtl/perf_event_monitor.sv
// ============================================================================
// perf_event_monitor
// ----------------------------------------------------------------------------
// Run-control and performance-counter block that sits beside the CPU and the
// caches.  It counts a bounded run of clock cycles and up to NUM_EVENTS
// single-cycle event strobes.  It freezes automatically once the cycle
// counter reaches CYCLE_LIMIT, and every count can be read through an
// addressed, zero-latency read port.
//
// Parameters
//   NUM_EVENTS  : number of event channels (1..15)
//   CNT_WIDTH   : width of every counter (8..32)
//   CYCLE_LIMIT : RUN cycles before auto-freeze, 0 = unlimited
//   ADDR_WIDTH  : read address width, 2^ADDR_WIDTH >= NUM_EVENTS+1
//
// Build option
//   PERF_SATURATE_EN : when defined, counters saturate at all-ones instead of
//                      wrapping to zero.  The overflow flag behaves the same
//                      way in both builds.
//
// Ports
//   CLK      in   system clock, all state changes on posedge
//   RESET    in   asynchronous active-high reset
//   START    in   begin or resume counting (level sampled)
//   STOP     in   manual freeze (level sampled)
//   CLEAR    in   zero all counters and flags, return to IDLE (level sampled)
//   EVENT    in   event strobes, bit k feeds counter k+1
//   RD_ADDR  in   0 = cycle counter, k = event counter k
//   RD_DATA  out  value of the selected counter
//   RD_OVF   out  sticky overflow flag of the selected counter
//   STATE    out  00 IDLE, 01 RUN, 10 FROZEN
//   DONE     out  cycle limit reached
// ============================================================================
module perf_event_monitor #(
    parameter int NUM_EVENTS  = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int CYCLE_LIMIT = 200,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  CLEAR,
    input  logic [NUM_EVENTS-1:0] EVENT,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic [CNT_WIDTH-1:0]  RD_DATA,
    output logic                  RD_OVF,
    output logic [1:0]            STATE,
    output logic                  DONE
);

    // Counter 0 is the cycle counter; counters 1..NUM_EVENTS follow the
    // event channels.
    localparam int NUM_CNT = NUM_EVENTS + 1;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] RUN    = 2'b01;
    localparam logic [1:0] FROZEN = 2'b10;

    localparam logic [CNT_WIDTH-1:0] LIMIT_VAL = CNT_WIDTH'(CYCLE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    // Parameter sanity checks, reported when the design is elaborated.
    if (CYCLE_LIMIT < 0 || longint'(CYCLE_LIMIT) >= (longint'(1) << CNT_WIDTH)) begin : gBadLimit
        $error("perf_event_monitor: CYCLE_LIMIT %0d does not fit in %0d-bit counter",
               CYCLE_LIMIT, CNT_WIDTH);
    end
    if (NUM_EVENTS < 1 || NUM_EVENTS > 15) begin : gBadEvents
        $error("perf_event_monitor: NUM_EVENTS %0d out of range 1..15", NUM_EVENTS);
    end
    if (CNT_WIDTH < 8 || CNT_WIDTH > 32) begin : gBadWidth
        $error("perf_event_monitor: CNT_WIDTH %0d out of range 8..32", CNT_WIDTH);
    end
    if ((longint'(1) << ADDR_WIDTH) < longint'(NUM_CNT)) begin : gBadAddr
        $error("perf_event_monitor: ADDR_WIDTH %0d too narrow for %0d counters",
               ADDR_WIDTH, NUM_CNT);
    end

    logic [1:0]           state;
    logic                 done;
    logic [CNT_WIDTH-1:0] cnt      [NUM_CNT];
    logic [NUM_CNT-1:0]   ovfFlags;

    logic [CNT_WIDTH-1:0] cntNext  [NUM_CNT];
    logic [NUM_CNT-1:0]   ovfNext;
    logic [NUM_CNT-1:0]   incEn;
    logic                 limitHit;

    logic [CNT_WIDTH-1:0] rdData;
    logic                 rdOvf;

    // Only RUN counts.  The cycle counter always advances in RUN; each event
    // counter advances when its strobe is high, all in parallel.
    assign incEn = (state == RUN) ? {EVENT, 1'b1} : '0;

    // Per-counter increment with overflow detection.  An increment from
    // all-ones sets the sticky flag and either wraps to zero or holds at
    // all-ones, depending on the build.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cntNext[i] = cnt[i];
            ovfNext[i] = ovfFlags[i];
            if (incEn[i]) begin
                if (&cnt[i]) begin
                    ovfNext[i] = 1'b1;
`ifdef PERF_SATURATE_EN
                    cntNext[i] = cnt[i];
`else
                    cntNext[i] = '0;
`endif
                end else begin
                    cntNext[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // The limit is reached on the edge where the cycle counter becomes
    // CYCLE_LIMIT, so the freeze and DONE land on that same edge and the
    // events of the limit cycle are still counted.
    assign limitHit = (CYCLE_LIMIT != 0) && incEn[0] && (cntNext[0] == LIMIT_VAL);

    // Run-control state, counters and flags.  CLEAR beats everything else;
    // within a state STOP beats START.  In FROZEN a START is honoured only
    // while DONE is low, so a completed run cannot be extended without CLEAR.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            done     <= 1'b0;
            ovfFlags <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
            end
        end else if (CLEAR) begin
            state    <= IDLE;
            done     <= 1'b0;
            ovfFlags <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            ovfFlags <= ovfNext;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= cntNext[i];
            end
            case (state)
                IDLE: begin
                    if (START && !STOP) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (STOP || limitHit) begin
                        state <= FROZEN;
                    end
                    if (limitHit) begin
                        done <= 1'b1;
                    end
                end
                FROZEN: begin
                    if (START && !STOP && !done) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Combinational read port straight off the registers, so a read in the
    // same cycle as an update shows the pre-edge value.  Addresses past the
    // last event counter read as zero.
    always_comb begin
        rdData = '0;
        rdOvf  = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (RD_ADDR == ADDR_WIDTH'(i)) begin
                rdData = cnt[i];
                rdOvf  = ovfFlags[i];
            end
        end
    end

    assign RD_DATA = rdData;
    assign RD_OVF  = rdOvf;
    assign STATE   = state;
    assign DONE    = done;

endmodule

// File: tb/tb_perf_event_monitor.sv
// ============================================================================
// tb_perf_event_monitor
// ----------------------------------------------------------------------------
// Directed bench for perf_event_monitor.  Instance dutA uses the default
// parameters (16-bit counters, limit 200); instance dutB uses 8-bit counters
// with no cycle limit for the wrap / saturate scenario.
// ============================================================================
module tb_perf_event_monitor;

    logic        clk = 1'b0;
    logic        reset;

    logic        startA, stopA, clearA;
    logic [3:0]  eventA;
    logic [3:0]  rdAddrA;
    logic [15:0] rdDataA;
    logic        rdOvfA;
    logic [1:0]  stateA;
    logic        doneA;

    logic        startB, stopB, clearB;
    logic [3:0]  eventB;
    logic [3:0]  rdAddrB;
    logic [7:0]  rdDataB;
    logic        rdOvfB;
    logic [1:0]  stateB;
    logic        doneB;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    perf_event_monitor #(
        .NUM_EVENTS(4), .CNT_WIDTH(16), .CYCLE_LIMIT(200), .ADDR_WIDTH(4)
    ) dutA (
        .CLK(clk), .RESET(reset), .START(startA), .STOP(stopA), .CLEAR(clearA),
        .EVENT(eventA), .RD_ADDR(rdAddrA), .RD_DATA(rdDataA), .RD_OVF(rdOvfA),
        .STATE(stateA), .DONE(doneA)
    );

    perf_event_monitor #(
        .NUM_EVENTS(4), .CNT_WIDTH(8), .CYCLE_LIMIT(0), .ADDR_WIDTH(4)
    ) dutB (
        .CLK(clk), .RESET(reset), .START(startB), .STOP(stopB), .CLEAR(clearB),
        .EVENT(eventB), .RD_ADDR(rdAddrB), .RD_DATA(rdDataB), .RD_OVF(rdOvfB),
        .STATE(stateB), .DONE(doneB)
    );

    // Advance to just after the next rising edge, where inputs are changed
    // and outputs are observed.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset asserted from time zero: everything reads as zero and IDLE.
    task automatic test_reset;
        reset = 1'b1;
        startA = 0; stopA = 0; clearA = 0; eventA = '0; rdAddrA = '0;
        startB = 0; stopB = 0; clearB = 0; eventB = '0; rdAddrB = '0;
        #2;
        vectors++;
        if (stateA !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_state got %b exp 00", stateA); end
        vectors++;
        if (rdDataA !== 16'd0 || rdOvfA !== 1'b0 || doneA !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_outputs got data %0d ovf %b done %b exp 0 0 0", rdDataA, rdOvfA, doneA);
        end
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    // One START cycle, ten cycles of EVENT[0], then STOP: the STOP edge still
    // counts as a RUN cycle, so the cycle counter ends at 11.
    task automatic test_basic_run;
        startA = 1'b1;
        tick(1);
        startA = 1'b0;
        eventA = 4'b0001;
        tick(10);
        eventA = 4'b0000;
        stopA  = 1'b1;
        tick(1);
        stopA  = 1'b0;
        rdAddrA = 4'd0; #1;
        vectors++;
        if (rdDataA !== 16'd11) begin miscompares++; $display("[TB] FAIL basic_cycles got %0d exp 11", rdDataA); end
        rdAddrA = 4'd1; #1;
        vectors++;
        if (rdDataA !== 16'd10) begin miscompares++; $display("[TB] FAIL basic_event1 got %0d exp 10", rdDataA); end
        rdAddrA = 4'd2; #1;
        vectors++;
        if (rdDataA !== 16'd0) begin miscompares++; $display("[TB] FAIL basic_event2 got %0d exp 0", rdDataA); end
        vectors++;
        if (stateA !== 2'b10 || doneA !== 1'b0) begin
            miscompares++; $display("[TB] FAIL basic_state got %b done %b exp 10 done 0", stateA, doneA);
        end
    endtask

    // All strobes high from START until the limit: FROZEN and DONE land on
    // the 200th RUN edge, every counter reads 200, and START cannot resume.
    task automatic test_auto_freeze;
        clearA = 1'b1;
        tick(1);
        clearA = 1'b0;
        vectors++;
        if (stateA !== 2'b00) begin miscompares++; $display("[TB] FAIL freeze_clear_state got %b exp 00", stateA); end
        startA = 1'b1;
        tick(1);
        startA = 1'b0;
        eventA = 4'b1111;
        tick(199);
        vectors++;
        if (stateA !== 2'b01 || doneA !== 1'b0) begin
            miscompares++; $display("[TB] FAIL freeze_edge199 got state %b done %b exp 01 done 0", stateA, doneA);
        end
        tick(1);
        vectors++;
        if (stateA !== 2'b10 || doneA !== 1'b1) begin
            miscompares++; $display("[TB] FAIL freeze_edge200 got state %b done %b exp 10 done 1", stateA, doneA);
        end
        for (int a = 0; a < 5; a++) begin
            rdAddrA = 4'(a); #1;
            vectors++;
            if (rdDataA !== 16'd200) begin miscompares++; $display("[TB] FAIL freeze_addr%0d got %0d exp 200", a, rdDataA); end
        end
        startA = 1'b1;
        tick(1);
        startA = 1'b0;
        rdAddrA = 4'd0; #1;
        vectors++;
        if (stateA !== 2'b10 || rdDataA !== 16'd200) begin
            miscompares++; $display("[TB] FAIL freeze_restart got state %b cycles %0d exp 10 200", stateA, rdDataA);
        end
        eventA = 4'b0000;
    endtask

    // CLEAR together with START while FROZEN and DONE: CLEAR wins.
    task automatic test_priority;
        clearA = 1'b1;
        startA = 1'b1;
        tick(1);
        clearA = 1'b0;
        startA = 1'b0;
        rdAddrA = 4'd0; #1;
        vectors++;
        if (stateA !== 2'b00 || doneA !== 1'b0) begin
            miscompares++; $display("[TB] FAIL prio_state got %b done %b exp 00 done 0", stateA, doneA);
        end
        vectors++;
        if (rdDataA !== 16'd0 || rdOvfA !== 1'b0) begin
            miscompares++; $display("[TB] FAIL prio_cycles got %0d ovf %b exp 0 0", rdDataA, rdOvfA);
        end
        rdAddrA = 4'd3; #1;
        vectors++;
        if (rdDataA !== 16'd0) begin miscompares++; $display("[TB] FAIL prio_event3 got %0d exp 0", rdDataA); end
        tick(1);
        vectors++;
        if (stateA !== 2'b00) begin miscompares++; $display("[TB] FAIL prio_stays_idle got %b exp 00", stateA); end
    endtask

    // STOP at cycle 50, twenty frozen cycles with EVENT active, then resume
    // and run the remaining 150 edges to the limit.
    task automatic test_resume;
        startA = 1'b1;
        tick(1);
        startA = 1'b0;
        eventA = 4'b0001;
        tick(49);
        stopA = 1'b1;
        tick(1);
        stopA = 1'b0;
        tick(20);
        rdAddrA = 4'd0; #1;
        vectors++;
        if (rdDataA !== 16'd50) begin miscompares++; $display("[TB] FAIL resume_held_cycles got %0d exp 50", rdDataA); end
        rdAddrA = 4'd1; #1;
        vectors++;
        if (rdDataA !== 16'd50 || stateA !== 2'b10) begin
            miscompares++; $display("[TB] FAIL resume_held_event1 got %0d state %b exp 50 state 10", rdDataA, stateA);
        end
        startA = 1'b1;
        tick(1);
        startA = 1'b0;
        tick(149);
        vectors++;
        if (stateA !== 2'b01 || doneA !== 1'b0) begin
            miscompares++; $display("[TB] FAIL resume_edge149 got state %b done %b exp 01 done 0", stateA, doneA);
        end
        tick(1);
        eventA = 4'b0000;
        rdAddrA = 4'd0; #1;
        vectors++;
        if (rdDataA !== 16'd200 || doneA !== 1'b1 || stateA !== 2'b10) begin
            miscompares++; $display("[TB] FAIL resume_final got cycles %0d done %b state %b exp 200 1 10", rdDataA, doneA, stateA);
        end
        rdAddrA = 4'd1; #1;
        vectors++;
        if (rdDataA !== 16'd200) begin miscompares++; $display("[TB] FAIL resume_final_event1 got %0d exp 200", rdDataA); end
    endtask

    // 8-bit counters, no limit: EVENT[1] for 260 edges, then one STOP edge.
    // The cycle counter sees 261 increments, event counter 2 sees 260.
    task automatic test_overflow;
        logic [7:0] expCycles;
        logic [7:0] expEvent2;
`ifdef PERF_SATURATE_EN
        expCycles = 8'd255;
        expEvent2 = 8'd255;
`else
        expCycles = 8'd5;
        expEvent2 = 8'd4;
`endif
        startB = 1'b1;
        tick(1);
        startB = 1'b0;
        eventB = 4'b0010;
        tick(260);
        eventB = 4'b0000;
        stopB  = 1'b1;
        tick(1);
        stopB  = 1'b0;
        rdAddrB = 4'd2; #1;
        vectors++;
        if (rdDataB !== expEvent2 || rdOvfB !== 1'b1) begin
            miscompares++; $display("[TB] FAIL ovf_event2 got %0d ovf %b exp %0d ovf 1", rdDataB, rdOvfB, expEvent2);
        end
        rdAddrB = 4'd0; #1;
        vectors++;
        if (rdDataB !== expCycles || rdOvfB !== 1'b1) begin
            miscompares++; $display("[TB] FAIL ovf_cycles got %0d ovf %b exp %0d ovf 1", rdDataB, rdOvfB, expCycles);
        end
        rdAddrB = 4'd1; #1;
        vectors++;
        if (rdDataB !== 8'd0 || rdOvfB !== 1'b0) begin
            miscompares++; $display("[TB] FAIL ovf_event1 got %0d ovf %b exp 0 ovf 0", rdDataB, rdOvfB);
        end
        rdAddrB = 4'd5; #1;
        vectors++;
        if (rdDataB !== 8'd0 || rdOvfB !== 1'b0) begin
            miscompares++; $display("[TB] FAIL ovf_bad_addr got %0d ovf %b exp 0 ovf 0", rdDataB, rdOvfB);
        end
        vectors++;
        if (stateB !== 2'b10 || doneB !== 1'b0) begin
            miscompares++; $display("[TB] FAIL ovf_state got %b done %b exp 10 done 0", stateB, doneB);
        end
    endtask

    // Bad addresses while counting, then reset between edges mid-RUN: the
    // outputs must drop before the next rising edge.
    task automatic test_async_reset_bad_addr;
        clearA = 1'b1;
        tick(1);
        clearA = 1'b0;
        startA = 1'b1;
        tick(1);
        startA = 1'b0;
        eventA = 4'b1111;
        tick(5);
        rdAddrA = 4'd0; #1;
        vectors++;
        if (rdDataA !== 16'd5) begin miscompares++; $display("[TB] FAIL async_precount got %0d exp 5", rdDataA); end
        rdAddrA = 4'd5; #1;
        vectors++;
        if (rdDataA !== 16'd0 || rdOvfA !== 1'b0) begin
            miscompares++; $display("[TB] FAIL bad_addr5 got %0d ovf %b exp 0 ovf 0", rdDataA, rdOvfA);
        end
        rdAddrA = 4'd15; #1;
        vectors++;
        if (rdDataA !== 16'd0) begin miscompares++; $display("[TB] FAIL bad_addr15 got %0d exp 0", rdDataA); end
        rdAddrA = 4'd4;
        reset = 1'b1;
        #1;
        vectors++;
        if (stateA !== 2'b00 || rdDataA !== 16'd0 || doneA !== 1'b0 || rdOvfA !== 1'b0) begin
            miscompares++; $display("[TB] FAIL async_reset got state %b data %0d done %b ovf %b exp 00 0 0 0",
                                    stateA, rdDataA, doneA, rdOvfA);
        end
        rdAddrB = 4'd0; #1;
        vectors++;
        if (stateB !== 2'b00 || rdDataB !== 8'd0 || rdOvfB !== 1'b0) begin
            miscompares++; $display("[TB] FAIL async_reset_b got state %b data %0d ovf %b exp 00 0 0", stateB, rdDataB, rdOvfB);
        end
        eventA = 4'b0000;
        tick(1);
        reset = 1'b0;
        tick(2);
        vectors++;
        if (stateA !== 2'b00 || rdDataA !== 16'd0) begin
            miscompares++; $display("[TB] FAIL post_reset got state %b data %0d exp 00 0", stateA, rdDataA);
        end
    endtask

    initial begin
        test_reset;
        test_basic_run;
        test_auto_freeze;
        test_priority;
        test_resume;
        test_overflow;
        test_async_reset_bad_addr;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
- Parametrised, synthesizable run-control and performance-counter block for the system top, placed beside the CPU and both caches.
- Counts a bounded run of clock cycles and up to NUM_EVENTS single-cycle event strobes (icache miss, dcache miss, stall, retire, ...).
- Freezes automatically at a programmable cycle limit and exposes every count through an addressed read port.
- Replaces fixed-length, print-based cycle observation with counters that can be checked in hardware and in benches.

Parameters:
- NUM_EVENTS, 4: number of event channels, 1..15.
- CNT_WIDTH, 16: width of every counter, 8..32.
- CYCLE_LIMIT, 200: RUN cycles before auto-freeze; 0 = unlimited.
- ADDR_WIDTH, 4: read-address width; requires 2^ADDR_WIDTH >= NUM_EVENTS+1.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  level-sampled; begin or resume counting.
- STOP  in  1  level-sampled; manual freeze.
- CLEAR  in  1  level-sampled; zero all counters, return to IDLE.
- EVENT  in  NUM_EVENTS  per-channel event strobe; bit k drives counter k+1.
- RD_ADDR  in  ADDR_WIDTH  0 = cycle counter, k = event counter k (1..NUM_EVENTS).
- RD_DATA  out  CNT_WIDTH  selected counter value.
- RD_OVF  out  1  sticky overflow flag of the selected counter.
- STATE  out  2  00 IDLE, 01 RUN, 10 FROZEN.
- DONE  out  1  cycle limit reached.

Behaviour:
- Reset (async, RESET=1): STATE=IDLE, all counters 0, all overflow flags 0, DONE=0, RD_DATA=0, RD_OVF=0. Reset mid-RUN aborts the run immediately with no partial update.
- Priority on any posedge: CLEAR > STOP > START.
- IDLE:
  - START=1 -> RUN.
  - No counting in the START cycle; EVENT is first sampled on the next posedge.
- RUN, every posedge:
  - Cycle counter += 1.
  - Event counter k += 1 where EVENT[k-1]=1; all channels update in parallel, simultaneous events each counted.
  - STOP=1 -> FROZEN. That edge still counts the cycle and its events.
  - CYCLE_LIMIT != 0 and cycle counter becomes CYCLE_LIMIT on this edge -> FROZEN and DONE=1 on the same edge. Events on the limit cycle are counted.
- FROZEN:
  - Counters hold; EVENT is ignored.
  - START with DONE=0 -> RUN; counting resumes from held values.
  - START with DONE=1 -> ignored.
- CLEAR (any state): counters, overflow flags and DONE -> 0; STATE -> IDLE on that edge. CLEAR with START in the same edge -> IDLE, not RUN.
- Counter width and wrap:
  - Width is CNT_WIDTH.
  - Increment from all-ones wraps to 0 and sets that counter's sticky overflow flag.
  - Overflow flags clear only on CLEAR or RESET.
  - CYCLE_LIMIT >= 2^CNT_WIDTH is illegal; the implementation flags it with a simulation-time check.
- Read port:
  - Purely combinational from registered state; zero latency.
  - RD_ADDR > NUM_EVENTS returns RD_DATA=0 and RD_OVF=0.
  - A read in the same cycle as an update returns the pre-edge value.
- DONE remains 1 until CLEAR or RESET.

Optional Feature:
- Macro: PERF_SATURATE_EN.
- Defined: counters saturate at all-ones instead of wrapping. The overflow flag sets on the first increment attempted while the counter is at all-ones; the value stays all-ones.
- Undefined: wrap-around behaviour as above.
- The cycle counter obeys the same rule in both builds.

Test Plan:
- Basic run: RESET, START one cycle, EVENT[0]=1 for 10 cycles, STOP -> addr0 equals cycles spent in RUN; addr1=10; STATE=10; DONE=0.
- Auto-freeze (CYCLE_LIMIT=200): START, all EVENT bits high every cycle -> FROZEN after exactly 200 RUN edges; DONE=1; addr0..addr4 all 200; a further START leaves STATE=10.
- Resume: STOP at cycle count 50, hold 20 cycles with EVENT active, START -> counts unchanged while frozen; DONE after 150 more edges; addr0=200.
- Overflow (CNT_WIDTH=8, CYCLE_LIMIT=0): EVENT[1] held 260 cycles -> wrap build: addr2=4, RD_OVF=1; PERF_SATURATE_EN build: addr2=255, RD_OVF=1.
- Priority: CLEAR and START asserted together in FROZEN -> IDLE, all counters 0, DONE=0.
- Async reset and bad address: RESET asserted mid-RUN between edges -> outputs 0 and STATE=00 before the next posedge. RD_ADDR=NUM_EVENTS+1 -> RD_DATA=0, RD_OVF=0.
